// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: sequencing controller for the word-serial AES round datapath.
// Accepts one 128-bit block, walks the datapath through the initial AddRoundKey
// and nr full rounds (four 32-bit words per round), then offers the ciphertext.
// Optional build macro: AES_ROUND_CTRL_PERF_EN adds blk_count / replay_count.
module aes_round_ctrl (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [1:0]   in_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic [3:0]   key_round,
  input  logic         key_valid,
  output logic [3:0]   dp_round,
  output logic [1:0]   dp_mode,
  output logic [1:0]   dp_width_sel,
  output logic [127:0] dp_data_in,
  input  logic [127:0] dp_data_out,
  output logic         busy
`ifdef AES_ROUND_CTRL_PERF_EN
  ,
  output logic [31:0]  blk_count,
  output logic [15:0]  replay_count
`endif
);

  typedef enum logic [1:0] {IDLE, ROUND0, RUN, DONE} state_e;

  state_e       state_q, state_d;
  logic [127:0] st_q, st_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [3:0]   nr_q, nr_d;
  logic [1:0]   wd_q, wd_d;
  logic [1:0]   md_q, md_d;

  // Next-state decode; st only ever loads in_data or a finished datapath round
  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    rnd_d   = rnd_q;
    nr_d    = nr_q;
    wd_d    = wd_q;
    md_d    = md_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          st_d    = in_data;
          rnd_d   = 4'd0;
          wd_d    = 2'd0;
          state_d = ROUND0;
          // mode 11 is folded onto AES-256 so the datapath never sees it
          case (in_mode)
            2'b00:   begin md_d = 2'b00; nr_d = 4'd10; end
            2'b01:   begin md_d = 2'b01; nr_d = 4'd12; end
            default: begin md_d = 2'b10; nr_d = 4'd14; end
          endcase
        end
      end
      ROUND0: begin
        if (key_valid) begin
          st_d    = dp_data_out;
          rnd_d   = 4'd1;
          wd_d    = 2'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        // word counter free-runs: the datapath accumulator cannot pause, so a
        // missing key at the last word replays the whole round instead
        wd_d = wd_q + 2'd1;
        if (wd_q == 2'd3 && key_valid) begin
          st_d = dp_data_out;
          if (rnd_q == nr_q) state_d = DONE;
          else               rnd_d   = rnd_q + 4'd1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and working registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      st_q    <= '0;
      rnd_q   <= 4'd0;
      nr_q    <= 4'd10;
      wd_q    <= 2'd0;
      md_q    <= 2'b00;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      rnd_q   <= rnd_d;
      nr_q    <= nr_d;
      wd_q    <= wd_d;
      md_q    <= md_d;
    end
  end

  // All outputs decode from registers only
  assign in_ready     = (state_q == IDLE);
  assign out_valid    = (state_q == DONE);
  assign busy         = (state_q != IDLE);
  assign out_data     = st_q;
  assign dp_data_in   = st_q;
  assign dp_mode      = md_q;
  assign dp_round     = (state_q == RUN) ? rnd_q : 4'd0;
  assign key_round    = (state_q == RUN) ? rnd_q : 4'd0;
  assign dp_width_sel = (state_q == RUN) ? wd_q  : 2'd0;

`ifdef AES_ROUND_CTRL_PERF_EN
  logic [31:0] blk_q;
  logic [15:0] rep_q;
  logic        miss;

  assign miss = !key_valid &&
                ((state_q == ROUND0) || (state_q == RUN && wd_q == 2'd3));

  // Completed-block counter (wraps) and key-miss counter (saturates)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_q <= '0;
      rep_q <= '0;
    end else begin
      if (state_q == DONE && out_ready) blk_q <= blk_q + 32'd1;
      if (miss && rep_q != 16'hFFFF)    rep_q <= rep_q + 16'd1;
    end
  end

  assign blk_count    = blk_q;
  assign replay_count = rep_q;
`endif

endmodule
